irq_ctrl: RTL and testbench

Six-source programmable interrupt controller sitting between external devices (timers, UART, etc.) and CP0's `HWInt[5:0]` input. It latches and prioritises device requests and presents the eligible set to CP0. When the CPU acknowledges an interrupt, it records the serviced source in an in-service register and holds lower-priority sources off until software issues end-of-interrupt. Software configures it through a memory-mapped register window on the system bridge.

---
 rtl/irq_ctrl.sv | 132 +++++++++++++
 tb/tb_irq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source prioritised interrupt controller driving CP0 HWInt[5:0].
// Define IRQ_CTRL_NEST_EN to let strictly higher-priority sources preempt an in-service one.
module irq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  src_in,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        int_ack,
    output logic [5:0]  hw_int,
    output logic [2:0]  vector
);
    localparam int unsigned NSRC   = 6;
    localparam int unsigned SYNC_W = SYNC_STAGES * NSRC;

    localparam logic [2:0] REG_PEND   = 3'd0;
    localparam logic [2:0] REG_ENABLE = 3'd1;
    localparam logic [2:0] REG_EDGE   = 3'd2;
    localparam logic [2:0] REG_ISR    = 3'd3;
    localparam logic [2:0] REG_VECTOR = 3'd4;
    localparam logic [2:0] VEC_NONE   = 3'd7;

    logic [SYNC_W-1:0] sync_q;
    logic [NSRC-1:0]   s_hist_q;
    logic [NSRC-1:0]   pend_q, pend_d;
    logic [NSRC-1:0]   enable_q, enable_d;
    logic [NSRC-1:0]   edge_mode_q, edge_mode_d;
    logic [NSRC-1:0]   isr_q, isr_d;
    logic [2:0]        vector_q, vector_d;
    logic              valid_q, valid_d;

    logic [NSRC-1:0]   s, pend, active, eligible, isr_low, ack_oh, rise, w1c;
    logic [2:0]        reg_sel;
    logic              eoi;
    logic              unused_bits;

    function automatic logic [2:0] lowest_id(input logic [NSRC-1:0] v);
        logic [2:0] id;
        id = VEC_NONE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) id = 3'(i);
        end
        return id;
    endfunction

    assign s           = sync_q[SYNC_W-1 -: NSRC];
    assign reg_sel     = addr[4:2];
    assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

    // Level-mode bits expose the synchronised line directly; edge-mode bits expose the latch.
    always_comb begin
        pend     = (edge_mode_q & pend_q) | (~edge_mode_q & s);
        active   = pend & enable_q & ~isr_q;
        isr_low  = isr_q & (~isr_q + NSRC'(1));
`ifdef IRQ_CTRL_NEST_EN
        // Mask below the highest-priority in-service bit; all ones when nothing is in service.
        eligible = active & (isr_low - NSRC'(1));
`else
        eligible = (isr_q == '0) ? active : '0;
`endif
        ack_oh   = int_ack ? (eligible & (~eligible + NSRC'(1))) : '0;
    end

    always_comb begin
        rise        = s & ~s_hist_q;
        w1c         = (we && reg_sel == REG_PEND) ? wdata[NSRC-1:0] : '0;
        eoi         = we && reg_sel == REG_VECTOR;
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        vector_d    = vector_q;
        valid_d     = valid_q;

        // A fresh edge wins over both W1C and ack clears.
        pend_d = edge_mode_q & ((pend_q & ~w1c & ~ack_oh) | rise);
        isr_d  = (eoi ? (isr_q & ~isr_low) : isr_q) | ack_oh;

        if (we && reg_sel == REG_ENABLE) enable_d    = wdata[NSRC-1:0];
        if (we && reg_sel == REG_EDGE)   edge_mode_d = wdata[NSRC-1:0];

        if (int_ack) begin
            if (ack_oh != '0) begin
                vector_d = lowest_id(ack_oh);
                valid_d  = 1'b1;
            end else begin
                vector_d = VEC_NONE;
                valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            s_hist_q    <= '0;
            pend_q      <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            isr_q       <= '0;
            vector_q    <= VEC_NONE;
            valid_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_W-NSRC-1:0], src_in};
            s_hist_q    <= s;
            pend_q      <= pend_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            isr_q       <= isr_d;
            vector_q    <= vector_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PEND:   rdata = 32'(pend);
            REG_ENABLE: rdata = 32'(enable_q);
            REG_EDGE:   rdata = 32'(edge_mode_q);
            REG_ISR:    rdata = 32'(isr_q);
            REG_VECTOR: rdata = {valid_q, 28'd0, vector_q};
            default:    rdata = '0;
        endcase
    end

    assign hw_int = eligible;
    assign vector = vector_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic checked against a cycle model of irq_ctrl.
module tb_irq_ctrl;
    localparam int SYNC = 2;

    logic        clk;
    logic        reset;
    logic [5:0]  src_in;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_ack;
    logic [5:0]  hw_int;
    logic [2:0]  vector;

    int total = 0;
    int bad   = 0;
    logic [5:0] src_cur;

    // Reference model state
    logic [5:0] m_hist [SYNC+1];
    logic [5:0] m_pend_e, m_en, m_edge, m_isr;
    logic [2:0] m_vec;
    logic       m_valid;

    irq_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .src_in(src_in), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .int_ack(int_ack), .hw_int(hw_int), .vector(vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest_isr();
        int h;
        h = 6;
        for (int i = 5; i >= 0; i--) if (m_isr[i]) h = i;
        return h;
    endfunction

    function automatic logic [5:0] model_pend();
        logic [5:0] p;
        logic [5:0] s;
        s = m_hist[SYNC-1];
        for (int i = 0; i < 6; i++) p[i] = m_edge[i] ? m_pend_e[i] : s[i];
        return p;
    endfunction

    function automatic logic [5:0] model_elig();
        logic [5:0] p, el;
        logic act;
        int h;
        p  = model_pend();
        h  = lowest_isr();
        el = '0;
        for (int i = 0; i < 6; i++) begin
            act = p[i] && m_en[i] && !m_isr[i];
`ifdef IRQ_CTRL_NEST_EN
            el[i] = act && (i < h);
`else
            el[i] = act && (h == 6);
`endif
        end
        return el;
    endfunction

    function automatic logic [31:0] model_reg(input int idx);
        case (idx)
            0: return {26'd0, model_pend()};
            1: return {26'd0, m_en};
            2: return {26'd0, m_edge};
            3: return {26'd0, m_isr};
            4: return {m_valid, 28'd0, m_vec};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int j = 0; j <= SYNC; j++) m_hist[j] = '0;
        m_pend_e = '0; m_en = '0; m_edge = '0; m_isr = '0;
        m_vec = 3'd7; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] src, input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic ack, input logic rst);
        logic [5:0] s, sd, el, np;
        int h, k;
        if (rst) begin
            model_reset();
            return;
        end
        s  = m_hist[SYNC-1];
        sd = m_hist[SYNC];
        el = model_elig();
        h  = lowest_isr();
        k  = -1;
        for (int i = 5; i >= 0; i--) if (el[i]) k = i;
        for (int i = 0; i < 6; i++) begin
            if (m_edge[i])
                np[i] = (s[i] && !sd[i]) ||
                        (m_pend_e[i] && !(w && a[4:2] == 3'd0 && d[i]) && !(ack && k == i));
            else
                np[i] = 1'b0;
        end
        if (w && a[4:2] == 3'd4 && h < 6) m_isr[h] = 1'b0;
        if (ack) begin
            if (k >= 0) begin m_isr[k] = 1'b1; m_vec = 3'(k); m_valid = 1'b1; end
            else begin m_vec = 3'd7; m_valid = 1'b0; end
        end
        m_pend_e = np;
        if (w && a[4:2] == 3'd1) m_en   = d[5:0];
        if (w && a[4:2] == 3'd2) m_edge = d[5:0];
        for (int j = SYNC; j >= 1; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = src;
    endtask

    // One clock: drive at the falling edge, model follows the rising edge, return at next falling edge.
    task automatic cyc(input logic [5:0] src, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic ack, input logic rst);
        src_in = src; we = w; addr = a; wdata = d; int_ack = ack; reset = rst;
        @(posedge clk);
        model_step(src, w, a, d, ack, rst);
        @(negedge clk);
        we = 1'b0; int_ack = 1'b0; reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(src_cur, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(src_cur, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic ack_once();
        cyc(src_cur, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic pulse(input logic [5:0] bits);
        src_cur = bits;
        idle(1);
        src_cur = '0;
        idle(2);
    endtask

    task automatic do_reset();
        src_cur = '0;
        cyc(6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        cyc(6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (hw_int !== 6'd0) begin bad++; $display("FAIL reset_hw_int: got %h want 00", hw_int); end
        total++; if (vector !== 3'd7) begin bad++; $display("FAIL reset_vector: got %0d want 7", vector); end
        for (int r = 0; r < 8; r++) begin
            addr = 5'(r * 4); #1;
            total++;
            if (rdata !== ((r == 4) ? 32'h7 : 32'h0)) begin
                bad++; $display("FAIL reset_reg%0d: got %h want %h", r, rdata, (r == 4) ? 32'h7 : 32'h0);
            end
        end
    endtask

    task automatic test_edge_ack();
        do_reset();
        wr(5'h04, 32'h3F);
        wr(5'h08, 32'h3F);
        src_cur = 6'h04; idle(1);
        src_cur = 6'h00; idle(1);
        total++; if (hw_int !== 6'h00) begin bad++; $display("FAIL edge_early: got %h want 00", hw_int); end
        idle(1);
        total++; if (hw_int !== 6'h04) begin bad++; $display("FAIL edge_hw_int: got %h want 04", hw_int); end
        ack_once();
        total++; if (vector !== 3'd2) begin bad++; $display("FAIL edge_vector: got %0d want 2", vector); end
        total++; if (hw_int !== 6'h00) begin bad++; $display("FAIL edge_ack_hw: got %h want 00", hw_int); end
        addr = 5'h0C; #1;
        total++; if (rdata !== 32'h4) begin bad++; $display("FAIL edge_isr: got %h want 4", rdata); end
        addr = 5'h00; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL edge_pend: got %h want 0", rdata); end
        addr = 5'h10; #1;
        total++; if (rdata !== 32'h8000_0002) begin bad++; $display("FAIL edge_vecreg: got %h want 80000002", rdata); end
        wr(5'h10, 32'h0);
        addr = 5'h0C; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL edge_eoi_isr: got %h want 0", rdata); end
    endtask

    task automatic test_priority();
        do_reset();
        wr(5'h04, 32'h3F);
        wr(5'h08, 32'h3F);
        src_cur = 6'h12; idle(3);
        total++; if (hw_int !== 6'h12) begin bad++; $display("FAIL prio_hw: got %h want 12", hw_int); end
        ack_once();
        total++; if (vector !== 3'd1) begin bad++; $display("FAIL prio_vector: got %0d want 1", vector); end
        total++; if (hw_int !== 6'h00) begin bad++; $display("FAIL prio_hold: got %h want 00", hw_int); end
        addr = 5'h0C; #1;
        total++; if (rdata !== 32'h2) begin bad++; $display("FAIL prio_isr: got %h want 2", rdata); end
        wr(5'h10, 32'h0);
        total++; if (hw_int !== 6'h10) begin bad++; $display("FAIL prio_after_eoi: got %h want 10", hw_int); end
        ack_once();
        total++; if (vector !== 3'd4) begin bad++; $display("FAIL prio_vector2: got %0d want 4", vector); end
        src_cur = 6'h00; idle(2);
    endtask

    task automatic test_nesting();
        logic [5:0] exp_hw;
        logic [2:0] exp_vec;
        logic [31:0] exp_isr;
        do_reset();
        wr(5'h04, 32'h3F);
        wr(5'h08, 32'h3F);
        pulse(6'h10);
        ack_once();
        pulse(6'h01);
`ifdef IRQ_CTRL_NEST_EN
        exp_hw = 6'h01;
`else
        exp_hw = 6'h00;
`endif
        total++; if (hw_int !== exp_hw) begin bad++; $display("FAIL nest_hw: got %h want %h", hw_int, exp_hw); end
        ack_once();
`ifdef IRQ_CTRL_NEST_EN
        exp_isr = 32'h11; exp_vec = 3'd0;
`else
        exp_isr = 32'h10; exp_vec = 3'd7;
`endif
        addr = 5'h0C; #1;
        total++; if (rdata !== exp_isr) begin bad++; $display("FAIL nest_isr: got %h want %h", rdata, exp_isr); end
        total++; if (vector !== exp_vec) begin bad++; $display("FAIL nest_vector: got %0d want %0d", vector, exp_vec); end
        wr(5'h10, 32'h0);
`ifdef IRQ_CTRL_NEST_EN
        exp_isr = 32'h10; exp_hw = 6'h00;
`else
        exp_isr = 32'h00; exp_hw = 6'h01;
`endif
        addr = 5'h0C; #1;
        total++; if (rdata !== exp_isr) begin bad++; $display("FAIL nest_eoi_isr: got %h want %h", rdata, exp_isr); end
        total++; if (hw_int !== exp_hw) begin bad++; $display("FAIL nest_eoi_hw: got %h want %h", hw_int, exp_hw); end
    endtask

    task automatic test_level();
        do_reset();
        wr(5'h04, 32'h3F);
        wr(5'h08, 32'h00);
        src_cur = 6'h08; idle(1);
        addr = 5'h00; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL lvl_early: got %h want 0", rdata); end
        idle(1);
        total++; if (hw_int !== 6'h08) begin bad++; $display("FAIL lvl_hw: got %h want 08", hw_int); end
        ack_once();
        addr = 5'h00; #1;
        total++; if (rdata !== 32'h8) begin bad++; $display("FAIL lvl_pend_after_ack: got %h want 8", rdata); end
        total++; if (hw_int !== 6'h00) begin bad++; $display("FAIL lvl_ack_hw: got %h want 00", hw_int); end
        wr(5'h10, 32'h0);
        total++; if (hw_int !== 6'h08) begin bad++; $display("FAIL lvl_reassert: got %h want 08", hw_int); end
        src_cur = 6'h00; idle(1);
        addr = 5'h00; #1;
        total++; if (rdata !== 32'h8) begin bad++; $display("FAIL lvl_drop1: got %h want 8", rdata); end
        idle(1);
        addr = 5'h00; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL lvl_drop2: got %h want 0", rdata); end
    endtask

    task automatic test_races();
        do_reset();
        wr(5'h08, 32'h3F);
        pulse(6'h20);
        src_cur = 6'h20; idle(1);
        src_cur = 6'h00; idle(1);
        wr(5'h00, 32'h20);
        addr = 5'h00; #1;
        total++; if (rdata !== 32'h20) begin bad++; $display("FAIL race_set_wins: got %h want 20", rdata); end
        wr(5'h00, 32'h20);
        addr = 5'h00; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL race_w1c: got %h want 0", rdata); end
        pulse(6'h20);
        wr(5'h04, 32'h20);
        ack_once();
        total++; if (vector !== 3'd5) begin bad++; $display("FAIL race_vec5: got %0d want 5", vector); end
        ack_once();
        total++; if (vector !== 3'd7) begin bad++; $display("FAIL spurious_vec: got %0d want 7", vector); end
        addr = 5'h10; #1;
        total++; if (rdata !== 32'h7) begin bad++; $display("FAIL spurious_valid: got %h want 7", rdata); end
        addr = 5'h0C; #1;
        total++; if (rdata !== 32'h20) begin bad++; $display("FAIL spurious_isr: got %h want 20", rdata); end
        src_cur = 6'h01; idle(3);
        cyc(src_cur, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        src_cur = 6'h00;
        total++; if (vector !== 3'd7) begin bad++; $display("FAIL rst_vec: got %0d want 7", vector); end
        total++; if (hw_int !== 6'h00) begin bad++; $display("FAIL rst_hw: got %h want 00", hw_int); end
        for (int r = 0; r < 4; r++) begin
            addr = 5'(r * 4); #1;
            total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0", r, rdata); end
        end
    endtask

    task automatic test_random();
        logic [5:0] exp_hw;
        logic [31:0] exp_rd;
        int ridx;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            src_cur = src_cur ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            cyc(src_cur, ($urandom_range(0, 3) == 0), 5'($urandom), 32'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
            exp_hw = model_elig();
            total++; if (hw_int !== exp_hw) begin bad++; $display("FAIL rnd_hw @%0d: got %h want %h", n, hw_int, exp_hw); end
            total++; if (vector !== m_vec) begin bad++; $display("FAIL rnd_vec @%0d: got %0d want %0d", n, vector, m_vec); end
            ridx = $urandom_range(0, 7);
            exp_rd = model_reg(ridx);
            addr = 5'((ridx * 4) + $urandom_range(0, 3)); #1;
            total++; if (rdata !== exp_rd) begin bad++; $display("FAIL rnd_reg%0d @%0d: got %h want %h", ridx, n, rdata, exp_rd); end
        end
    endtask

    initial begin
        reset = 1'b1; src_in = '0; we = 1'b0; addr = '0; wdata = '0; int_ack = 1'b0;
        src_cur = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_edge_ack();
        test_priority();
        test_nesting();
        test_level();
        test_races();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
